mrc_iter_ec: RTL and testbench

MRC_ITER_EC -- requirements
Module: mrc_iter_ec

---
 rtl/mrc_iter_ec_pkg.sv | 59 +++++
 rtl/mrc_iter_ec_if.sv | 24 ++
 rtl/mrc_iter_ec_submul.sv | 22 ++
 rtl/mrc_iter_ec.sv | 138 +++++++++++++
 tb/tb_mrc_iter_ec.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mrc_iter_ec_pkg.sv
// Shared definitions for the iterative mixed-radix converter: modulus table,
// modular-inverse table (built at elaboration), FSM states and sign codes.
package mrc_pkg;

    localparam int MAX_DIG = 8;
    localparam int MOD_W   = 18;

    typedef logic [MAX_DIG-1:0][MOD_W-1:0]              mod_tab_t;
    typedef logic [MAX_DIG-1:0][MAX_DIG-1:0][MOD_W-1:0] inv_tab_t;

    // Odd 18-bit moduli 2^18-c, c in {5,11,17,23,27,35,41,45}. None has a
    // prime factor <= 23 and every pairwise difference factors into primes
    // <= 17, so the set is pairwise coprime. MOD[0] is the rightmost entry.
    localparam mod_tab_t MOD = {
        18'd262099, 18'd262103, 18'd262109, 18'd262117,
        18'd262121, 18'd262127, 18'd262133, 18'd262139
    };

    typedef enum logic [1:0] {IDLE, CONV, SIGN, DONE} mrc_state_e;

    localparam logic [1:0] SIGN_POS = 2'b00;
    localparam logic [1:0] SIGN_NEG = 2'b01;
    localparam logic [1:0] SIGN_ERR = 2'b10;

    // Inverse of a modulo m by the extended Euclidean algorithm.
    function automatic logic [MOD_W-1:0] mod_inv(input longint a, input longint m);
        longint t, nt, r, nr, q, tmp;
        t  = 0;
        nt = 1;
        r  = m;
        nr = a % m;
        for (int it = 0; it < 64; it++) begin
            if (nr != 0) begin
                q   = r / nr;
                tmp = t - q * nt;
                t   = nt;
                nt  = tmp;
                tmp = r - q * nr;
                r   = nr;
                nr  = tmp;
            end
        end
        if (t < 0) t = t + m;
        return MOD_W'(t);
    endfunction

    // INV[k][j] = MOD[k]^-1 mod MOD[j]; the diagonal is never used.
    function automatic inv_tab_t gen_inv();
        inv_tab_t tab;
        tab = '0;
        for (int k = 0; k < MAX_DIG; k++)
            for (int j = 0; j < MAX_DIG; j++)
                if (k != j) tab[k][j] = mod_inv(longint'(MOD[k]), longint'(MOD[j]));
        return tab;
    endfunction

    localparam inv_tab_t INV = gen_inv();

endpackage

// File: rtl/mrc_iter_ec_if.sv
// Handshake bundle of the converter: residue input stream and
// mixed-radix/sign result stream.
interface mrc_iter_ec_if #(
    parameter int DATA_WIDTH = 18,
    parameter int N          = 6
);
    logic                    in_valid;
    logic                    in_ready;
    logic [N*DATA_WIDTH-1:0] res_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [N*DATA_WIDTH-1:0] mr_out;
    logic [1:0]              sign_out;

    modport master (
        output in_valid, res_in, out_ready,
        input  in_ready, out_valid, mr_out, sign_out
    );

    modport slave (
        input  in_valid, res_in, out_ready,
        output in_ready, out_valid, mr_out, sign_out
    );
endinterface

// File: rtl/mrc_iter_ec_submul.sv
// One mixed-radix step: ((a - b) mod m) * inverse mod m.
module mrc_submul #(
    parameter int DATA_WIDTH = 18
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] modulus,
    input  logic [DATA_WIDTH-1:0] inverse,
    output logic [DATA_WIDTH-1:0] digit
);
    logic [DATA_WIDTH-1:0]   diff;
    logic [2*DATA_WIDTH-1:0] prod;

    // Modular difference then full-width product, reduced below the modulus.
    // The wrap of a-b is undone by adding m, so the result always fits.
    always_comb begin
        diff = a - b;
        if (a < b) diff = diff + modulus;
        prod  = {{DATA_WIDTH{1'b0}}, diff} * {{DATA_WIDTH{1'b0}}, inverse};
        digit = DATA_WIDTH'(prod % {{DATA_WIDTH{1'b0}}, modulus});
    end
endmodule

// File: rtl/mrc_iter_ec.sv
// Iterative residue-to-mixed-radix converter with sign detection.
// One (k,j) step per CONV cycle through a single shared submul unit.
// Macro MRC_REDUNDANT_CHECK_EN: derive sign from the redundant digits and
// flag inconsistent ones as an error; otherwise sign comes from the top
// non-redundant digit.
module mrc_iter_ec
    import mrc_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int NUM_DIG    = 4,
    parameter int NUM_RED    = 2
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [(NUM_DIG+NUM_RED)*DATA_WIDTH-1:0]   res_in,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [(NUM_DIG+NUM_RED)*DATA_WIDTH-1:0]   mr_out,
    output logic [1:0]                                sign_out
);
    localparam int N = NUM_DIG + NUM_RED;

    typedef logic [N-1:0][DATA_WIDTH-1:0] dig_vec_t;

    mrc_state_e            state_q, state_d;
    dig_vec_t              r_q, r_d;
    logic [2:0]            k_q, k_d, j_q, j_d;
    logic [1:0]            sign_q, sign_d, sign_calc;
    logic [DATA_WIDTH-1:0] op_a, op_b, op_mod, op_inv, digit;

    // Operand fetch for the current (k,j) pair.
    always_comb begin
        op_a   = r_q[j_q];
        op_b   = r_q[k_q];
        op_mod = DATA_WIDTH'(MOD[j_q]);
        op_inv = DATA_WIDTH'(INV[k_q][j_q]);
    end

    mrc_submul #(.DATA_WIDTH(DATA_WIDTH)) u_submul (
        .a       (op_a),
        .b       (op_b),
        .modulus (op_mod),
        .inverse (op_inv),
        .digit   (digit)
    );

`ifdef MRC_REDUNDANT_CHECK_EN
    logic all_zero, all_max;

    // Redundant digits must be all 0 (positive) or all MOD-1 (negative).
    always_comb begin
        all_zero = 1'b1;
        all_max  = 1'b1;
        for (int i = NUM_DIG; i < N; i++) begin
            if (r_q[i] != '0) all_zero = 1'b0;
            if (r_q[i] != DATA_WIDTH'(MOD[i] - 18'd1)) all_max = 1'b0;
        end
        sign_calc = all_zero ? SIGN_POS : (all_max ? SIGN_NEG : SIGN_ERR);
    end
`else
    // Upper half of the top non-redundant digit range means negative.
    always_comb begin
        sign_calc = (r_q[NUM_DIG-1] > DATA_WIDTH'((MOD[NUM_DIG-1] - 18'd1) >> 1))
                    ? SIGN_NEG : SIGN_POS;
    end
`endif

    // Next-state logic, (k,j) sequencing and handshake outputs.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        k_d       = k_q;
        j_d       = j_q;
        sign_d    = sign_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    r_d     = res_in;
                    k_d     = 3'd0;
                    j_d     = 3'd1;
                    state_d = CONV;
                end
            end
            CONV: begin
                r_d[j_q] = digit;
                if (j_q == 3'(N-1)) begin
                    if (k_q == 3'(N-2)) begin
                        state_d = SIGN;
                    end else begin
                        k_d = k_q + 3'd1;
                        j_d = k_q + 3'd2;
                    end
                end else begin
                    j_d = j_q + 3'd1;
                end
            end
            SIGN: begin
                sign_d  = sign_calc;
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    k_d     = 3'd0;
                    j_d     = 3'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and working registers; reset discards any in-flight result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            k_q     <= 3'd0;
            j_q     <= 3'd1;
            sign_q  <= SIGN_POS;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            k_q     <= k_d;
            j_q     <= j_d;
            sign_q  <= sign_d;
        end
    end

    assign mr_out   = r_q;
    assign sign_out = sign_q;

endmodule

// File: tb/tb_mrc_iter_ec.sv
// Self-checking bench for mrc_iter_ec. The reference works forwards: a test
// value is chosen as its mixed-radix digit vector, residues are derived from
// it by Horner evaluation, and the DUT must return the original digits.
module tb_mrc_iter_ec;
    import mrc_pkg::*;

    localparam int DW = 18;
    localparam int ND = 4;
    localparam int NR = 2;
    localparam int N  = ND + NR;
    localparam int T  = N * (N - 1) / 2;

    typedef logic [DW-1:0] dig_t [N];
    typedef struct {
        logic [N*DW-1:0] mr;
        logic [1:0]      sign;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    mrc_iter_ec_if #(.DATA_WIDTH(DW), .N(N)) bus ();

    mrc_iter_ec #(.DATA_WIDTH(DW), .NUM_DIG(ND), .NUM_RED(NR)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .res_in    (bus.res_in),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .mr_out    (bus.mr_out),
        .sign_out  (bus.sign_out)
    );

    always #5 clk = ~clk;

    int   checks = 0, errors = 0;
    int   cyc = 0;
    int   ready_mode = 1;     // 0 hold low, 1 hold high, 2 random
    bit   mon_en = 1'b0;
    bit   pending = 1'b0;
    int   acc_edge = 0;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Residue of the value with mixed-radix digits d, modulo MOD[i].
    function automatic logic [DW-1:0] res_of(input dig_t d, input int i);
        longint unsigned acc, p;
        acc = 0;
        p   = longint'(MOD[i]);
        for (int k = N - 1; k >= 0; k--)
            acc = (acc * longint'(MOD[k]) + longint'(d[k])) % p;
        return DW'(acc);
    endfunction

    function automatic logic [N*DW-1:0] pack(input dig_t d);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = d[i];
        return v;
    endfunction

    function automatic logic [1:0] exp_sign(input dig_t d);
`ifdef MRC_REDUNDANT_CHECK_EN
        bit z, m;
        z = 1'b1;
        m = 1'b1;
        for (int i = ND; i < N; i++) begin
            if (d[i] != '0) z = 1'b0;
            if (d[i] != DW'(MOD[i] - 18'd1)) m = 1'b0;
        end
        return z ? 2'b00 : (m ? 2'b01 : 2'b10);
`else
        return (d[ND-1] > DW'((MOD[ND-1] - 18'd1) / 2)) ? 2'b01 : 2'b00;
`endif
    endfunction

    // Per-cycle comparison against the transaction-level model.
    always @(negedge clk) begin
        bit exp_ov, acc, hs;
        if (mon_en) begin
            if (!reset_n) begin
                pending = 1'b0;
                exp_q.delete();
            end else begin
                exp_ov = pending && (cyc - acc_edge >= T + 1);
                chk("out_valid", bus.out_valid, exp_ov);
                chk("in_ready", bus.in_ready, !pending);
                chk("sign_legal", bus.sign_out == 2'b11, 0);
                if (exp_ov) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard: result with nothing expected");
                    end else begin
                        chk("mr_out", bus.mr_out, exp_q[0].mr);
                        chk("sign_out", bus.sign_out, exp_q[0].sign);
                    end
                end
                acc = bus.in_valid && !pending;
                hs  = exp_ov && bus.out_ready;
                if (hs) begin
                    pending = 1'b0;
                    if (exp_q.size() > 0) exp_q.delete(0);
                end
                if (acc) begin
                    pending  = 1'b1;
                    acc_edge = cyc + 1;
                end
            end
        end
    end

    task automatic send(input dig_t d);
        exp_t e;
        dig_t r;
        int   n;
        e.mr   = pack(d);
        e.sign = exp_sign(d);
        exp_q.push_back(e);
        for (int i = 0; i < N; i++) r[i] = res_of(d, i);
        bus.res_in   = pack(r);
        bus.in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 300);
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send: in_ready never rose");
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Returns number of negedges until out_valid is seen.
    task automatic wait_valid(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 100);
        if (!bus.out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: out_valid timeout", name);
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pending) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || pending) begin
            checks++;
            errors++;
            $display("FAIL %s: result never consumed", name);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        dig_t d, lit;
        int   n, k;
        longint unsigned p, m5, d5;

        bus.in_valid = 1'b0;
        bus.res_in   = '0;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_mr_out", bus.mr_out, 0);
        chk("rst_sign", bus.sign_out, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        mon_en = 1'b1;

        // Pin the residue model with hand-known values.
        for (int i = 0; i < N; i++) d[i] = '0;
        d[0] = 18'd1;
        for (int i = 0; i < N; i++) chk($sformatf("model_x1_r%0d", i), res_of(d, i), 1);
        for (int i = 0; i < N; i++) d[i] = DW'(MOD[i] - 18'd1);
        for (int i = 0; i < N; i++) chk($sformatf("model_xm1_r%0d", i), res_of(d, i), MOD[i] - 18'd1);

        // x = 0: everything zero, result after T+1 edges (seen at negedge T+2).
        ready_mode = 0;
        for (int i = 0; i < N; i++) d[i] = '0;
        send(d);
        wait_valid("x0", n);
        chk("x0_latency", n, T + 2);
        chk("x0_mr", bus.mr_out, 0);
        chk("x0_sign", bus.sign_out, 2'b00);
        ready_mode = 1;
        wait_done("x0");

        // x = 1.
        ready_mode = 0;
        d[0] = 18'd1;
        send(d);
        wait_valid("x1", n);
        chk("x1_latency", n, T + 2);
        chk("x1_a0", bus.mr_out[DW-1:0], 1);
        chk("x1_upper", bus.mr_out[N*DW-1:DW], 0);
        chk("x1_sign", bus.sign_out, 2'b00);

        // x = -1, then hold out_ready low with in_valid pulses.
        ready_mode = 1;
        wait_done("x1");
        ready_mode = 0;
        for (int i = 0; i < N; i++) d[i] = DW'(MOD[i] - 18'd1);
        send(d);
        wait_valid("xm1", n);
        for (int i = 0; i < N; i++)
            chk($sformatf("xm1_a%0d", i), bus.mr_out[i*DW +: DW], MOD[i] - 18'd1);
        chk("xm1_sign", bus.sign_out, 2'b01);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            bus.in_valid = c[0];
            bus.res_in   = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_in_ready", bus.in_ready, 0);
            for (int i = 0; i < N; i++)
                chk("stall_mr", bus.mr_out[i*DW +: DW], MOD[i] - 18'd1);
            chk("stall_sign", bus.sign_out, 2'b01);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        ready_mode = 1;
        wait_done("xm1");

        // x = 5 with residue 5 bumped by one: a0..a4 = 5,0,0,0,0 and a5 is
        // the inverse of MOD[0]*..*MOD[4] modulo MOD[5].
        m5 = longint'(MOD[5]);
        p  = 1;
        for (int i = 0; i < 5; i++) p = (p * longint'(MOD[i])) % m5;
        d5 = 0;
        for (longint unsigned c = 1; c < m5; c++)
            if ((p * c) % m5 == 1) begin
                d5 = c;
                break;
            end
        for (int i = 0; i < N; i++) d[i] = '0;
        d[0] = 18'd5;
        d[5] = DW'(d5);
        for (int i = 0; i < N; i++) lit[i] = (i == 5) ? 18'd6 : 18'd5;
        for (int i = 0; i < N; i++) chk($sformatf("model_x5_r%0d", i), res_of(d, i), lit[i]);
        ready_mode = 0;
        send(d);
        wait_valid("x5", n);
        chk("x5_a0", bus.mr_out[DW-1:0], 5);
        chk("x5_a1_a4", bus.mr_out[5*DW-1:DW], 0);
`ifdef MRC_REDUNDANT_CHECK_EN
        chk("x5_sign", bus.sign_out, 2'b10);
`else
        chk("x5_sign", bus.sign_out, 2'b00);
`endif
        ready_mode = 1;
        wait_done("x5");

        // Reset at CONV cycle 7 discards the conversion.
        for (int i = 0; i < N; i++) d[i] = DW'(MOD[i] - 18'd1);
        send(d);
        repeat (6) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_mr", bus.mr_out, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < N; i++) d[i] = '0;
        d[0] = 18'd1;
        send(d);
        wait_done("after_reset_x1");

        // Randomized traffic with random back-pressure and sign boundaries.
        ready_mode = 2;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) d[i] = DW'($urandom_range(0, int'(MOD[i]) - 1));
            case ($urandom_range(0, 4))
                1: for (int i = ND; i < N; i++) d[i] = '0;
                2: for (int i = ND; i < N; i++) d[i] = DW'(MOD[i] - 18'd1);
                3: d[ND-1] = DW'((MOD[ND-1] - 18'd1) / 2);
                4: d[ND-1] = DW'((MOD[ND-1] - 18'd1) / 2 + 1);
                default: ;
            endcase
            send(d);
            k = $urandom_range(0, 2);
            repeat (k) begin
                @(posedge clk);
                #1;
            end
        end
        wait_done("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
